mc_control: RTL and testbench
=============================

MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, giving the maximum number of cycles spent waiting for mem_ready in one memory state (legal range 2..255).
REQ-002 Port sys_clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 Port sys_rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port opcode, input, 6 bits: instruction bits [31:26] from the instruction register.
REQ-005 Port funct, input, 6 bits: instruction bits [5:0].
REQ-006 Port mem_ready, input, 1 bit: the shared memory has completed the current read or write.
REQ-007 Port MemRead and port MemWrite, output, 1 bit each: memory access strobes.
REQ-008 Port IorD, output, 1 bit: memory address select (0 = PC, 1 = ALU result register).
REQ-009 Port IRWrite and port PCWrite, output, 1 bit each: instruction register load and unconditional PC load.
REQ-010 Port Branch, output, 1 bit: PC load qualified by the ALU zero flag.
REQ-011 Port PCSrc, output, 2 bits: 00 = ALU, 01 = ALUOut, 10 = jump target.
REQ-012 Port ALUSrcA, output, 1 bit: 0 = PC, 1 = rd1.
REQ-013 Port ALUSrcB, output, 2 bits: 00 = rd2, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2.
REQ-014 Port ALUOp, output, 3 bits: ADD=000, SUB=001, AND=010, OR=011, SLT=100.
REQ-015 Port RegDst, MemtoReg and RegWrite, output, 1 bit each: register-file destination select (0 = rt, 1 = rd), write-back source select (0 = ALU, 1 = memory) and write enable.
REQ-016 Port state, output, 4 bits: current state encoding, for debug.
REQ-017 Port instr_done, illegal and mem_err, output, 1 bit each: status pulses.

Function
REQ-018 The block SHALL be a Moore FSM with the following state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Encodings 12 to 15 SHALL go to FETCH on the next edge.
REQ-019 Outputs SHALL be decoded combinationally from the state, with mem_ready qualification and the funct-based ALUOp as the only input-dependent terms; any output not listed for a state SHALL be 0.
REQ-020 In FETCH the block SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD and PCSrc=00, with IRWrite=PCWrite=mem_ready. FETCH SHALL go to DECODE when mem_ready=1.
REQ-021 In DECODE the block SHALL drive ALUSrcA=0, ALUSrcB=11 and ALUOp=ADD. Next state by opcode:
- 100011 (lw) or 101011 (sw) -> MEMADR
- 000000 -> EXECUTE
- 000100 -> BRANCH
- 001000 -> ADDIEX
- 000010 -> JUMP
- any other opcode -> FETCH, with illegal=1 for that cycle.
REQ-022 A DECODE with opcode 000000 and funct not in {100000, 100010, 100100, 100101, 101010} SHALL go to FETCH with illegal=1.
REQ-023 In MEMADR the block SHALL drive ALUSrcA=1, ALUSrcB=10 and ALUOp=ADD, and go to MEMREAD for lw or MEMWRITE for sw.
REQ-024 In MEMREAD the block SHALL drive IorD=1 and MemRead=1, and go to MEMWB when mem_ready=1.
REQ-025 In MEMWB the block SHALL drive RegDst=0, MemtoReg=1 and RegWrite=1, then go to FETCH.
REQ-026 In MEMWRITE the block SHALL drive IorD=1 and MemWrite=1, and go to FETCH when mem_ready=1.
REQ-027 In EXECUTE the block SHALL drive ALUSrcA=1 and ALUSrcB=00, with ALUOp mapped from funct: 100000->ADD, 100010->SUB, 100100->AND, 100101->OR, 101010->SLT. EXECUTE SHALL then go to ALUWB.
REQ-028 In ALUWB the block SHALL drive RegDst=1, MemtoReg=0 and RegWrite=1, then go to FETCH.
REQ-029 In BRANCH the block SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCSrc=01 and Branch=1, then go to FETCH.
REQ-030 ADDIEX SHALL drive ALUSrcA=1, ALUSrcB=10 and ALUOp=ADD, then go to ADDIWB. ADDIWB SHALL drive RegDst=0, MemtoReg=0 and RegWrite=1, then go to FETCH.
REQ-031 In JUMP the block SHALL drive PCSrc=10 and PCWrite=1, then go to FETCH.
REQ-032 instr_done SHALL be 1 in each of the following, and 0 otherwise:
- MEMWB
- ALUWB
- BRANCH
- ADDIWB
- JUMP
- MEMWRITE while mem_ready=1.
REQ-033 Wait counter, 8 bits wide:
- It SHALL clear on every state change.
- It SHALL increment each cycle spent in FETCH, MEMREAD or MEMWRITE with mem_ready=0.
REQ-034 When the wait counter equals TIMEOUT-1 and mem_ready=0, the next state SHALL be FETCH and mem_err SHALL be 1 for that cycle. PCWrite, IRWrite and RegWrite SHALL remain 0 in that cycle.
REQ-035 When mem_ready=1 arrives in the same cycle as the timeout condition, mem_ready SHALL win: normal transition, mem_err=0.
REQ-036 Strobes SHALL be held steady while waiting. MemRead and MemWrite SHALL never be 1 in the same cycle.

Reset
REQ-037 While sys_rst=1, state SHALL be FETCH, the wait counter SHALL be 0, and all control and status outputs SHALL be forced to 0, including FETCH's MemRead.
REQ-038 Assertion of sys_rst mid-instruction SHALL abort immediately and asynchronously, without waiting for a clock edge.
REQ-039 After sys_rst deasserts, the first rising edge SHALL evaluate FETCH normally.

Verification
REQ-040 Reset, then lw (opcode 100011) with mem_ready=1 every cycle -> state sequence 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4; instr_done=1 in state 4.
REQ-041 R-type with funct 101010 and mem_ready=1 -> states 0,1,6,7,0; ALUOp=100 in state 6; RegDst=1 in state 7.
REQ-042 sw with mem_ready held 0 for 3 cycles in MEMWRITE, then 1 -> MemWrite=1 for 4 cycles, then FETCH; instr_done=1 only on the ready cycle; mem_err=0 throughout.
REQ-043 TIMEOUT=4, mem_ready stuck 0 in FETCH -> mem_err=1 on the 4th wait cycle, state re-enters FETCH, PCWrite=0 throughout.
REQ-044 Opcode 111111, or opcode 000000 with funct 000001, in DECODE -> illegal=1 for one cycle and next state FETCH.
REQ-045 sys_rst pulsed asynchronously while in BRANCH -> state=0 and all outputs 0 before the next clock edge; normal fetch resumes after release.

Source files
------------

// File: rtl/mc_control.sv
// Multicycle instruction-sequencing FSM: Moore controls decoded from the state, one state per cycle.
// Memory states stall on mem_ready with a bounded wait; reset aborts asynchronously and forces outputs low.
module mc_control #(
   parameter int TIMEOUT = 16
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       mem_ready,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IorD,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       Branch,
   output logic [1:0] PCSrc,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUOp,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic [3:0] state,
   output logic       instr_done,
   output logic       illegal,
   output logic       mem_err
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTE  = 4'd6,
      S_ALUWB    = 4'd7,
      S_BRANCH   = 4'd8,
      S_ADDIEX   = 4'd9,
      S_ADDIWB   = 4'd10,
      S_JUMP     = 4'd11
   } state_t;

   typedef struct packed {
      logic       mem_read;
      logic       mem_write;
      logic       iord;
      logic       ir_write;
      logic       pc_write;
      logic       branch;
      logic [1:0] pc_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_op;
      logic       reg_dst;
      logic       memto_reg;
      logic       reg_write;
      logic       instr_done;
      logic       illegal;
      logic       mem_err;
   } ctl_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b100;

   localparam logic [7:0] L_WAIT_LAST = 8'(TIMEOUT - 1);

   state_t     r_state;
   state_t     w_next;
   state_t     w_dec_next;
   logic [7:0] r_wait_cnt;
   logic       w_wait_state;
   logic       w_timeout;
   logic       w_funct_ok;
   logic [2:0] w_funct_op;
   logic       w_dec_ok;
   ctl_t       w_ctl;

   assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                         (r_state == S_MEMWRITE);
   // mem_ready has priority over an expiring wait budget
   assign w_timeout    = w_wait_state && !mem_ready && (r_wait_cnt == L_WAIT_LAST);

   always_comb begin
      w_funct_ok = 1'b1;
      w_funct_op = ALU_ADD;
      case (funct)
         F_ADD:   w_funct_op = ALU_ADD;
         F_SUB:   w_funct_op = ALU_SUB;
         F_AND:   w_funct_op = ALU_AND;
         F_OR:    w_funct_op = ALU_OR;
         F_SLT:   w_funct_op = ALU_SLT;
         default: w_funct_ok = 1'b0;
      endcase
   end

   always_comb begin
      w_dec_next = S_FETCH;
      w_dec_ok   = 1'b1;
      case (opcode)
         OP_LW, OP_SW: w_dec_next = S_MEMADR;
         OP_RTYPE: begin
            if (w_funct_ok) w_dec_next = S_EXECUTE;
            else            w_dec_ok   = 1'b0;
         end
         OP_BEQ:  w_dec_next = S_BRANCH;
         OP_ADDI: w_dec_next = S_ADDIEX;
         OP_J:    w_dec_next = S_JUMP;
         default: w_dec_ok   = 1'b0;
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH:    if (mem_ready) w_next = S_DECODE;
         S_DECODE:   w_next = w_dec_next;
         S_MEMADR:   w_next = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  if (mem_ready) w_next = S_MEMWB;
         S_MEMWB:    w_next = S_FETCH;
         S_MEMWRITE: if (mem_ready) w_next = S_FETCH;
         S_EXECUTE:  w_next = S_ALUWB;
         S_ALUWB:    w_next = S_FETCH;
         S_BRANCH:   w_next = S_FETCH;
         S_ADDIEX:   w_next = S_ADDIWB;
         S_ADDIWB:   w_next = S_FETCH;
         S_JUMP:     w_next = S_FETCH;
         default:    w_next = S_FETCH;
      endcase
      if (w_timeout) w_next = S_FETCH;
   end

   // A timeout re-entering FETCH counts as a state change for the wait counter
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_state    <= S_FETCH;
         r_wait_cnt <= '0;
      end else begin
         r_state <= w_next;
         if ((w_next != r_state) || w_timeout) r_wait_cnt <= '0;
         else if (w_wait_state && !mem_ready)  r_wait_cnt <= r_wait_cnt + 8'd1;
      end
   end

   always_comb begin
      w_ctl = '0;
      case (r_state)
         S_FETCH: begin
            w_ctl.mem_read  = 1'b1;
            w_ctl.alu_src_b = 2'b01;
            w_ctl.ir_write  = mem_ready;
            w_ctl.pc_write  = mem_ready;
         end
         S_DECODE: begin
            w_ctl.alu_src_b = 2'b11;
            w_ctl.illegal   = ~w_dec_ok;
         end
         S_MEMADR: begin
            w_ctl.alu_src_a = 1'b1;
            w_ctl.alu_src_b = 2'b10;
         end
         S_MEMREAD: begin
            w_ctl.iord     = 1'b1;
            w_ctl.mem_read = 1'b1;
         end
         S_MEMWB: begin
            w_ctl.memto_reg  = 1'b1;
            w_ctl.reg_write  = 1'b1;
            w_ctl.instr_done = 1'b1;
         end
         S_MEMWRITE: begin
            w_ctl.iord       = 1'b1;
            w_ctl.mem_write  = 1'b1;
            w_ctl.instr_done = mem_ready;
         end
         S_EXECUTE: begin
            w_ctl.alu_src_a = 1'b1;
            w_ctl.alu_op    = w_funct_op;
         end
         S_ALUWB: begin
            w_ctl.reg_dst    = 1'b1;
            w_ctl.reg_write  = 1'b1;
            w_ctl.instr_done = 1'b1;
         end
         S_BRANCH: begin
            w_ctl.alu_src_a  = 1'b1;
            w_ctl.alu_op     = ALU_SUB;
            w_ctl.pc_src     = 2'b01;
            w_ctl.branch     = 1'b1;
            w_ctl.instr_done = 1'b1;
         end
         S_ADDIEX: begin
            w_ctl.alu_src_a = 1'b1;
            w_ctl.alu_src_b = 2'b10;
         end
         S_ADDIWB: begin
            w_ctl.reg_write  = 1'b1;
            w_ctl.instr_done = 1'b1;
         end
         S_JUMP: begin
            w_ctl.pc_src     = 2'b10;
            w_ctl.pc_write   = 1'b1;
            w_ctl.instr_done = 1'b1;
         end
         default: w_ctl = '0;
      endcase
      w_ctl.mem_err = w_timeout;
   end

   // Gating with sys_rst directly makes the abort visible without a clock edge
   assign {MemRead, MemWrite, IorD, IRWrite, PCWrite, Branch, PCSrc, ALUSrcA, ALUSrcB,
           ALUOp, RegDst, MemtoReg, RegWrite, instr_done, illegal, mem_err}
          = sys_rst ? '0 : w_ctl;
   assign state = r_state;

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: directed scenarios plus random instruction streams against a path-based model.
module tb_mc_control;
   localparam int TO = 4;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic [5:0] opcode = '0;
   logic [5:0] funct = '0;
   logic       mem_ready = 1'b0;
   logic       MemRead, MemWrite, IorD, IRWrite, PCWrite, Branch;
   logic [1:0] PCSrc;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [2:0] ALUOp;
   logic       RegDst, MemtoReg, RegWrite;
   logic [3:0] state;
   logic       instr_done, illegal, mem_err;

   mc_control #(.TIMEOUT(TO)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .opcode(opcode), .funct(funct),
      .mem_ready(mem_ready), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
      .IRWrite(IRWrite), .PCWrite(PCWrite), .Branch(Branch), .PCSrc(PCSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegDst(RegDst),
      .MemtoReg(MemtoReg), .RegWrite(RegWrite), .state(state),
      .instr_done(instr_done), .illegal(illegal), .mem_err(mem_err)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct packed {
      logic       mem_read, mem_write, iord, ir_write, pc_write, branch;
      logic [1:0] pc_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_op;
      logic       reg_dst, memto_reg, reg_write, instr_done, illegal, mem_err;
      logic [3:0] st;
   } ctl_t;

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
   localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

   int total = 0;
   int bad = 0;
   int m_s = 0;
   int m_w = 0;

   function automatic ctl_t dut_ctl();
      ctl_t c;
      c.mem_read = MemRead;   c.mem_write = MemWrite; c.iord = IorD;
      c.ir_write = IRWrite;   c.pc_write = PCWrite;   c.branch = Branch;
      c.pc_src = PCSrc;       c.alu_src_a = ALUSrcA;  c.alu_src_b = ALUSrcB;
      c.alu_op = ALUOp;       c.reg_dst = RegDst;     c.memto_reg = MemtoReg;
      c.reg_write = RegWrite; c.instr_done = instr_done;
      c.illegal = illegal;    c.mem_err = mem_err;    c.st = state;
      return c;
   endfunction

   function automatic bit funct_legal(logic [5:0] fn);
      return fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
             fn == 6'b100101 || fn == 6'b101010;
   endfunction

   function automatic logic [2:0] funct_alu(logic [5:0] fn);
      if (fn == 6'b100010) return 3'b001;
      if (fn == 6'b100100) return 3'b010;
      if (fn == 6'b100101) return 3'b011;
      if (fn == 6'b101010) return 3'b100;
      return 3'b000;
   endfunction

   function automatic bit is_wait(int s);
      return s == 0 || s == 3 || s == 5;
   endfunction

   function automatic bit model_to();
      return is_wait(m_s) && !mem_ready && (m_w == TO - 1);
   endfunction

   // Each instruction class walks a fixed list of states; stalls hold, the end returns to FETCH
   function automatic int path_next(int s, logic [5:0] op, logic [5:0] fn, logic rdy);
      int q[$];
      if (s >= 12) return 0;
      if (is_wait(s) && !rdy) return s;
      q = '{0, 1};
      if (op == LW) q = '{0, 1, 2, 3, 4};
      else if (op == SW) q = '{0, 1, 2, 5};
      else if (op == RT && funct_legal(fn)) q = '{0, 1, 6, 7};
      else if (op == BEQ) q = '{0, 1, 8};
      else if (op == ADDI) q = '{0, 1, 9, 10};
      else if (op == JMP) q = '{0, 1, 11};
      foreach (q[i]) if (q[i] == s) return (i + 1 < q.size()) ? q[i + 1] : 0;
      return 0;
   endfunction

   function automatic ctl_t model_ctl();
      ctl_t c;
      c = '0;
      c.st = 4'(m_s);
      case (m_s)
         0: begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = mem_ready; c.pc_write = mem_ready; end
         1: begin
            c.alu_src_b = 2'b11;
            c.illegal = !(opcode inside {LW, SW, BEQ, ADDI, JMP} || (opcode == RT && funct_legal(funct)));
         end
         2: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
         3: begin c.iord = 1; c.mem_read = 1; end
         4: begin c.memto_reg = 1; c.reg_write = 1; c.instr_done = 1; end
         5: begin c.iord = 1; c.mem_write = 1; c.instr_done = mem_ready; end
         6: begin c.alu_src_a = 1; c.alu_op = funct_alu(funct); end
         7: begin c.reg_dst = 1; c.reg_write = 1; c.instr_done = 1; end
         8: begin c.alu_src_a = 1; c.alu_op = 3'b001; c.pc_src = 2'b01; c.branch = 1; c.instr_done = 1; end
         9: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
         10: begin c.reg_write = 1; c.instr_done = 1; end
         11: begin c.pc_src = 2'b10; c.pc_write = 1; c.instr_done = 1; end
         default: c = '0;
      endcase
      c.mem_err = model_to();
      return c;
   endfunction

   task automatic model_adv();
      bit to;
      int nx;
      to = model_to();
      nx = to ? 0 : path_next(m_s, opcode, funct, mem_ready);
      if (nx != m_s || to) m_w = 0;
      else if (is_wait(m_s) && !mem_ready) m_w = m_w + 1;
      m_s = nx;
   endtask

   task automatic tick();
      model_adv();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic do_reset();
      sys_rst = 1'b1;
      @(posedge sys_clk);
      #1;
      sys_rst = 1'b0;
      m_s = 0;
      m_w = 0;
   endtask

   task automatic test_reset();
      ctl_t act, exp;
      sys_rst = 1'b1; mem_ready = 1'b1; opcode = LW;
      #2;
      act = dut_ctl(); total++;
      if (act !== '0) begin bad++; $display("FAIL reset_hold: got %h want 0", act); end
      @(posedge sys_clk); #1;
      act = dut_ctl(); total++;
      if (act !== '0) begin bad++; $display("FAIL reset_edge: got %h want 0", act); end
      sys_rst = 1'b0; m_s = 0; m_w = 0;
      #1;
      act = dut_ctl(); exp = model_ctl(); total++;
      if (act !== exp) begin bad++; $display("FAIL reset_release: got %h want %h", act, exp); end
   endtask

   task automatic test_lw();
      int seq[6] = '{0, 1, 2, 3, 4, 0};
      ctl_t act, exp;
      do_reset();
      opcode = LW; funct = 6'h15; mem_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         act = dut_ctl(); exp = model_ctl();
         total++;
         if (act !== exp) begin bad++; $display("FAIL lw_model c%0d: got %h want %h", i, act, exp); end
         total++;
         if (int'(act.st) != seq[i] || act.reg_write !== (seq[i] == 4) || act.instr_done !== (seq[i] == 4)) begin
            bad++; $display("FAIL lw_seq c%0d: st=%0d rw=%b done=%b want st=%0d", i, act.st, act.reg_write, act.instr_done, seq[i]);
         end
         tick();
      end
   endtask

   task automatic test_rtype();
      int seq[5] = '{0, 1, 6, 7, 0};
      ctl_t act, exp;
      do_reset();
      opcode = RT; funct = 6'b101010; mem_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         act = dut_ctl(); exp = model_ctl();
         total++;
         if (act !== exp) begin bad++; $display("FAIL rtype_model c%0d: got %h want %h", i, act, exp); end
         total++;
         if (int'(act.st) != seq[i] || (seq[i] == 6 && act.alu_op !== 3'b100) || (seq[i] == 7 && act.reg_dst !== 1'b1)) begin
            bad++; $display("FAIL rtype_seq c%0d: st=%0d aluop=%b regdst=%b want st=%0d", i, act.st, act.alu_op, act.reg_dst, seq[i]);
         end
         tick();
      end
   endtask

   task automatic test_sw_wait();
      bit rdy[8] = '{1, 1, 1, 0, 0, 0, 1, 1};
      int seq[8] = '{0, 1, 2, 5, 5, 5, 5, 0};
      int n_mw, n_done, n_err;
      ctl_t act, exp;
      n_mw = 0; n_done = 0; n_err = 0;
      do_reset();
      opcode = SW; funct = 6'h00;
      for (int i = 0; i < 8; i++) begin
         mem_ready = rdy[i];
         #1;
         act = dut_ctl(); exp = model_ctl();
         total++;
         if (act !== exp || int'(act.st) != seq[i]) begin
            bad++; $display("FAIL sw_wait c%0d: got %h want %h st_want=%0d", i, act, exp, seq[i]);
         end
         if (act.mem_write) n_mw++;
         if (act.instr_done && act.st == 4'd5) n_done++;
         if (act.mem_err) n_err++;
         tick();
      end
      total++;
      if (n_mw != 4 || n_done != 1 || n_err != 0) begin
         bad++; $display("FAIL sw_counts: memwrite=%0d done=%0d err=%0d want 4/1/0", n_mw, n_done, n_err);
      end
   endtask

   task automatic test_timeout();
      int n_err;
      ctl_t act, exp;
      n_err = 0;
      do_reset();
      opcode = LW; mem_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         #1;
         act = dut_ctl(); exp = model_ctl();
         total++;
         if (act !== exp) begin bad++; $display("FAIL timeout_model c%0d: got %h want %h", i, act, exp); end
         total++;
         if (act.mem_err !== ((i % TO) == TO - 1) || act.st !== 4'd0 || act.pc_write !== 1'b0 || act.ir_write !== 1'b0) begin
            bad++; $display("FAIL timeout_c%0d: err=%b st=%0d pcw=%b want err=%b st=0 pcw=0", i, act.mem_err, act.st, act.pc_write, (i % TO) == TO - 1);
         end
         if (act.mem_err) n_err++;
         tick();
      end
      total++;
      if (n_err != 2) begin bad++; $display("FAIL timeout_count: got %0d want 2", n_err); end
   endtask

   task automatic test_illegal();
      logic [5:0] ops[2] = '{6'b111111, 6'b000000};
      logic [5:0] fns[2] = '{6'b100000, 6'b000001};
      int seq[3] = '{0, 1, 0};
      ctl_t act, exp;
      for (int k = 0; k < 2; k++) begin
         do_reset();
         opcode = ops[k]; funct = fns[k]; mem_ready = 1'b1;
         for (int i = 0; i < 3; i++) begin
            #1;
            act = dut_ctl(); exp = model_ctl();
            total++;
            if (act !== exp || int'(act.st) != seq[i] || act.illegal !== (i == 1)) begin
               bad++; $display("FAIL illegal k%0d c%0d: got %h want %h", k, i, act, exp);
            end
            tick();
         end
      end
   endtask

   task automatic test_async_reset();
      ctl_t act, exp;
      do_reset();
      opcode = BEQ; mem_ready = 1'b1;
      tick(); tick();
      #1;
      act = dut_ctl(); exp = model_ctl();
      total++;
      if (act !== exp || act.st !== 4'd8) begin bad++; $display("FAIL branch_reach: got %h want %h", act, exp); end
      sys_rst = 1'b1;
      #1;
      act = dut_ctl();
      total++;
      if (act !== '0) begin bad++; $display("FAIL async_abort: got %h want 0", act); end
      @(posedge sys_clk); #1;
      sys_rst = 1'b0; m_s = 0; m_w = 0;
      opcode = LW;
      for (int i = 0; i < 3; i++) begin
         #1;
         act = dut_ctl(); exp = model_ctl();
         total++;
         if (act !== exp || int'(act.st) != i) begin bad++; $display("FAIL resume c%0d: got %h want %h", i, act, exp); end
         tick();
      end
   endtask

   task automatic test_random();
      logic [5:0] pool[6] = '{LW, SW, RT, BEQ, ADDI, JMP};
      logic [5:0] fpool[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      int thr_pool[3] = '{95, 60, 20};
      int thr;
      ctl_t act, exp;
      thr = 95;
      do_reset();
      for (int i = 0; i < 800; i++) begin
         if (m_s == 0) begin
            opcode = ($urandom_range(0, 7) == 0) ? 6'($urandom) : pool[$urandom_range(0, 5)];
            funct = ($urandom_range(0, 9) < 7) ? fpool[$urandom_range(0, 4)] : 6'($urandom);
            thr = thr_pool[$urandom_range(0, 2)];
         end
         mem_ready = ($urandom_range(0, 99) < thr);
         #1;
         act = dut_ctl(); exp = model_ctl();
         total++;
         if (act !== exp) begin bad++; $display("FAIL random c%0d: got %h want %h", i, act, exp); end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_rtype();
      test_sw_wait();
      test_timeout();
      test_illegal();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
